if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised fetch/decode decoupling queue between IF and ID. It buffers up to DEPTH fetched entries: PC+2, instruction, branch flag and decoded halt flag. It supports independent producer/consumer stalls, a whole-queue flush on branch redirect, and a sticky halt that stops fetch. When the queue is empty it presents a canonical NOP bubble to ID.

## Interface
- PC_W, 16, width of incremented PC
- INSTR_W, 16, instruction width
- DEPTH, 4, entries; any integer ≥1, power of two not required
- OPC_W, 4, opcode field width, taken from instr[INSTR_W-1 -: OPC_W]
- HLT_OPC, 4'hF, opcode that marks halt
- NOP_INSTR, 16'h7000, instruction presented when out_valid=0
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries and the incoming push
- in_valid  in  1  IF presents an entry
- in_ready  out  1  queue accepts an entry this cycle
- pc_in  in  PC_W  incremented PC
- instr_in  in  INSTR_W  fetched instruction
- branch_in  in  1  instruction is a branch
- out_valid  out  1  head entry valid
- out_ready  in  1  ID consumes the head (~stall)
- pc_out  out  PC_W  head PC; 0 when empty
- instr_out  out  INSTR_W  head instruction; NOP_INSTR when empty
- branch_out  out  1  head branch flag; 0 when empty
- hlt_out  out  1  head is a halt; 0 when empty
- count  out  $clog2(DEPTH+1)  occupancy
- halted  out  1  a halt has been accepted and not yet flushed

## Operation
- Push: in_valid && in_ready. in_ready = (count<DEPTH) && !halted. Registered state only; no combinational path from out_ready.
- Pop: out_valid && out_ready. out_valid = (count≠0).
- Push and pop in the same cycle: count is unchanged. This is legal when full only if in_ready=1, so in practice push is blocked when full.
- hlt flag is decoded at push: opcode field == HLT_OPC. Accepting a halt sets halted. No further pushes occur until flush or rst.
- Entries queued ahead of a halt and the halt itself still drain to ID normally.
- Flush, which has priority over push and pop: count←0, pointers←0, halted←0. The incoming push is dropped and no pop is counted.
- Read and write pointers wrap from DEPTH-1 to 0. count is the sole full/empty indicator.
- Empty head: out_valid=0, instr_out=NOP_INSTR, pc_out=0, branch_out=0, hlt_out=0. These values are forced by a mux, not read from storage.
- Reset: identical to flush. All outputs take their empty values; in_ready=1, count=0, halted=0.
- Storage contents are not reset. Only pointers, count and halted are reset.

## Timing
- Latency push→head: 1 cycle into an empty queue. The entry pushed at edge N is visible on outputs after edge N.
- Head outputs are combinational from registered storage and read pointer. There is no out_ready→out path.
- in_ready, out_valid, count and halted are functions of registered state only.
- Flush asserted at edge N: empty values and in_ready=1 appear after edge N. A push attempted in the flush cycle is lost.
- Flush and rst asserted together: same result.
- A halt accepted at edge N drops in_ready after edge N.

## Structure
- Package if_id_pkg holds:
  - if_id_entry_t struct {pc, instr, branch, hlt}, parametrised by PC_W/INSTR_W via the package defaults
  - default HLT_OPC and NOP_INSTR constants
- One sub-module, if_id_queue_ram: a DEPTH×entry register array with one write port and one asynchronous read port. It has no reset.
- Top level holds the pointers, count, halted, handshake logic and empty-bubble mux.

## Test plan
- Reset, then idle: instr_out=16'h7000, out_valid=0, in_ready=1, count=0.
- Push 4 entries (pc 2,4,6,8) with out_ready=0 → count=4 and in_ready=0; a 5th push is refused. Then out_ready=1 → heads emerge in order 2,4,6,8, and count returns to 0.
- DEPTH=3 build: push/pop 10 entries continuously, streaming with out_ready=1 → order preserved across wrap, and count never exceeds 1.
- Push halt 16'hF000 after 2 entries → halted=1 and in_ready=0. Drain yields two entries then hlt_out=1. in_ready stays 0.
- With count=3, assert flush together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, instr_out=16'h7000; the pushed entry never appears.
- Assert rst mid-stream with halted=1 and count=2 → next cycle all empty values, halted=0, in_ready=1.

Source files
------------

// File: rtl/if_id_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : if_id_pkg
//  Purpose    : Shared types and constants for the IF/ID decoupling queue.
//               Holds the default halt opcode, the default bubble
//               instruction, the entry record layout and a width helper.
//  Revision   : 1.0 - initial release
// ============================================================================
package if_id_pkg;

  localparam int PC_W_DEFAULT    = 16;
  localparam int INSTR_W_DEFAULT = 16;

  // Opcode (top instruction bits) that marks a halt.
  localparam logic [3:0]  HLT_OPC_DEFAULT   = 4'hF;
  // Instruction shown to ID whenever the queue is empty.
  localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h7000;

  // One queued fetch record, at the package default widths.
  typedef struct packed {
    logic [PC_W_DEFAULT-1:0]    pc;
    logic [INSTR_W_DEFAULT-1:0] instr;
    logic                       branch;
    logic                       hlt;
  } if_id_entry_t;

  // Flattened entry width for arbitrary PC/instruction widths:
  // pc, instr, branch flag and halt flag.
  function automatic int entry_w(input int pc_w, input int instr_w);
    return pc_w + instr_w + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_queue_if.sv
`default_nettype none
// ============================================================================
//  Interface  : if_id_queue_if
//  Purpose    : Handshake bundle between the fetch/decode side and the queue.
//  Ports      : master - environment (drives flush, push data, out_ready)
//               slave  - queue (drives in_ready, head outputs, count, halted)
//  Revision   : 1.0 - initial release
// ============================================================================
interface if_id_queue_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    pc_in;
  logic [INSTR_W-1:0] instr_in;
  logic               branch_in;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instr_out;
  logic               branch_out;
  logic               hlt_out;
  logic [CNT_W-1:0]   count;
  logic               halted;

  modport master (
    output flush, in_valid, pc_in, instr_in, branch_in, out_ready,
    input  in_ready, out_valid, pc_out, instr_out, branch_out, hlt_out,
           count, halted
  );

  modport slave (
    input  flush, in_valid, pc_in, instr_in, branch_in, out_ready,
    output in_ready, out_valid, pc_out, instr_out, branch_out, hlt_out,
           count, halted
  );

endinterface
`default_nettype wire

// File: rtl/if_id_queue_ram.sv
`default_nettype none
// ============================================================================
//  Module     : if_id_queue_ram
//  Purpose    : DEPTH x WIDTH register array, one synchronous write port and
//               one asynchronous read port. Contents are never reset.
//  Ports      : clk     - clock
//               we_i    - write enable
//               waddr_i - write index
//               wdata_i - write data
//               raddr_i - read index
//               rdata_o - read data (combinational from storage)
//  Revision   : 1.0 - initial release
// ============================================================================
module if_id_queue_ram #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  wire logic             clk,
  input  wire logic             we_i,
  input  wire logic [PTR_W-1:0] waddr_i,
  input  wire logic [WIDTH-1:0] wdata_i,
  input  wire logic [PTR_W-1:0] raddr_i,
  output logic      [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Pointers are always kept below DEPTH by the owner, so the index is
  // always in range even when DEPTH is not a power of two.
  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module     : if_id_queue
//  Purpose    : Fetch/decode decoupling queue. Buffers up to DEPTH fetched
//               entries (PC+2, instruction, branch flag, decoded halt flag),
//               supports a whole-queue flush and a sticky halt that blocks
//               further fetch. An empty queue presents a NOP bubble.
//  Ports      : clk - clock, rst - synchronous active-high reset
//               bus - if_id_queue_if.slave (push side, head side, count,
//                     halted, flush)
//  Revision   : 1.0 - initial release
// ============================================================================
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 16,
  parameter int                 DEPTH     = 4,
  parameter int                 OPC_W     = 4,
  parameter logic [OPC_W-1:0]   HLT_OPC   = OPC_W'(HLT_OPC_DEFAULT),
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
  input wire logic      clk,
  input wire logic      rst,
  if_id_queue_if.slave  bus
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = entry_w(PC_W, INSTR_W);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             halted_q, halted_d;

  logic               in_ready;
  logic               out_valid;
  logic               push;
  logic               pop;
  logic               in_hlt;
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] rd_data;
  logic [PC_W-1:0]    rd_pc;
  logic [INSTR_W-1:0] rd_instr;
  logic               rd_branch;
  logic               rd_hlt;

  // Handshake depends on registered state only.
  assign in_ready  = (count_q < FULL_CNT) && !halted_q;
  assign out_valid = (count_q != '0);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;

  // Halt is decoded once, on the way in, and stored with the entry.
  assign in_hlt  = (bus.instr_in[INSTR_W-1 -: OPC_W] == HLT_OPC);
  assign wr_data = {bus.pc_in, bus.instr_in, bus.branch_in, in_hlt};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    halted_d = halted_q;
    if (bus.flush) begin
      // Flush wins over any push or pop in the same cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      halted_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (push && in_hlt) begin
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  if_id_queue_ram #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (push && !bus.flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign {rd_pc, rd_instr, rd_branch, rd_hlt} = rd_data;

  // Empty head shows a canonical bubble, never stale storage.
  assign bus.out_valid  = out_valid;
  assign bus.pc_out     = out_valid ? rd_pc     : '0;
  assign bus.instr_out  = out_valid ? rd_instr  : NOP_INSTR;
  assign bus.branch_out = out_valid ? rd_branch : 1'b0;
  assign bus.hlt_out    = out_valid ? rd_hlt    : 1'b0;
  assign bus.in_ready   = in_ready;
  assign bus.count      = count_q;
  assign bus.halted     = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module     : tb_if_id_queue
//  Purpose    : Self-checking bench for if_id_queue (DEPTH=4 and DEPTH=3
//               instances) using a scoreboard queue of expected heads.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;
  import if_id_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  if_id_entry_t sb[$];

  if_id_queue_if #(.PC_W(16), .INSTR_W(16), .DEPTH(4)) ia ();
  if_id_queue_if #(.PC_W(16), .INSTR_W(16), .DEPTH(3)) ib ();

  if_id_queue #(.DEPTH(4)) u_a (.clk(clk), .rst(rst), .bus(ia));
  if_id_queue #(.DEPTH(3)) u_b (.clk(clk), .rst(rst), .bus(ib));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ia.flush = 1'b0; ia.in_valid = 1'b0; ia.pc_in = '0; ia.instr_in = '0;
    ia.branch_in = 1'b0; ia.out_ready = 1'b0;
    ib.flush = 1'b0; ib.in_valid = 1'b0; ib.pc_in = '0; ib.instr_in = '0;
    ib.branch_in = 1'b0; ib.out_ready = 1'b0;
  endtask

  task automatic drive_a(input if_id_entry_t e);
    ia.in_valid = 1'b1; ia.pc_in = e.pc; ia.instr_in = e.instr;
    ia.branch_in = e.branch;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    total++; if (ia.instr_out !== 16'h7000) begin bad++; $display("FAIL reset_instr got=%h exp=7000", ia.instr_out); end
    total++; if (ia.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ia.out_valid); end
    total++; if (ia.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ia.in_ready); end
    total++; if (ia.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", ia.count); end
    total++; if (ia.pc_out !== 16'h0 || ia.halted !== 1'b0) begin bad++; $display("FAIL reset_pc_halt got=%h/%b exp=0/0", ia.pc_out, ia.halted); end
    tick();
    total++; if (ia.count !== 3'd0 || ib.count !== 2'd0 || ib.in_ready !== 1'b1) begin bad++; $display("FAIL idle_state got=%0d/%0d/%b exp=0/0/1", ia.count, ib.count, ib.in_ready); end
  endtask

  task automatic test_fill_drain();
    if_id_entry_t e, exp;
    ia.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = '{pc: 16'(2 * (i + 1)), instr: 16'h1000 + 16'(i), branch: i[0], hlt: 1'b0};
      drive_a(e); sb.push_back(e); tick();
      total++; if (ia.count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", ia.count, i + 1); end
    end
    ia.in_valid = 1'b0;
    total++; if (ia.in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", ia.in_ready); end
    e = '{pc: 16'd10, instr: 16'h1004, branch: 1'b0, hlt: 1'b0};
    drive_a(e); tick(); ia.in_valid = 1'b0;
    total++; if (ia.count !== 3'd4) begin bad++; $display("FAIL full_refuse got=%0d exp=4", ia.count); end
    ia.out_ready = 1'b1;
    for (int g = 0; g < 8 && sb.size() > 0; g++) begin
      exp = sb.pop_front();
      total++; if (ia.out_valid !== 1'b1 || {ia.pc_out, ia.instr_out, ia.branch_out, ia.hlt_out} !== exp) begin
        bad++; $display("FAIL drain_head got=%h/%h/%b/%b exp=%h/%h/%b/%b", ia.pc_out, ia.instr_out, ia.branch_out, ia.hlt_out, exp.pc, exp.instr, exp.branch, exp.hlt);
      end
      tick();
    end
    ia.out_ready = 1'b0;
    total++; if (ia.count !== 3'd0 || ia.out_valid !== 1'b0 || sb.size() != 0) begin bad++; $display("FAIL drain_empty got=%0d/%b left=%0d exp=0/0/0", ia.count, ia.out_valid, sb.size()); end
  endtask

  task automatic test_back_to_back();
    if_id_entry_t e, exp;
    bit exp_valid;
    sb.delete();
    ib.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      e = '{pc: 16'h0100 + 16'(2 * i), instr: 16'h2000 + 16'(i), branch: (i % 3 == 0), hlt: 1'b0};
      exp_valid = (sb.size() != 0);
      total++; if (ib.out_valid !== exp_valid || ib.in_ready !== 1'b1) begin bad++; $display("FAIL stream_valid got=%b/%b exp=%b/1", ib.out_valid, ib.in_ready, exp_valid); end
      if (exp_valid) begin
        exp = sb.pop_front();
        total++; if ({ib.pc_out, ib.instr_out, ib.branch_out, ib.hlt_out} !== exp) begin
          bad++; $display("FAIL stream_head got=%h/%h/%b exp=%h/%h/%b", ib.pc_out, ib.instr_out, ib.branch_out, exp.pc, exp.instr, exp.branch);
        end
      end
      ib.in_valid = 1'b1; ib.pc_in = e.pc; ib.instr_in = e.instr; ib.branch_in = e.branch;
      sb.push_back(e);
      tick();
      total++; if (ib.count !== 2'd1) begin bad++; $display("FAIL stream_count got=%0d exp=1", ib.count); end
    end
    ib.in_valid = 1'b0;
    for (int g = 0; g < 4 && sb.size() > 0; g++) begin
      exp = sb.pop_front();
      total++; if (ib.out_valid !== 1'b1 || {ib.pc_out, ib.instr_out, ib.branch_out, ib.hlt_out} !== exp) begin
        bad++; $display("FAIL stream_tail got=%h/%h exp=%h/%h", ib.pc_out, ib.instr_out, exp.pc, exp.instr);
      end
      tick();
    end
    ib.out_ready = 1'b0;
    total++; if (ib.count !== 2'd0 || sb.size() != 0) begin bad++; $display("FAIL stream_end got=%0d left=%0d exp=0/0", ib.count, sb.size()); end
  endtask

  task automatic test_halt();
    if_id_entry_t e, exp;
    if_id_entry_t seq[3];
    sb.delete();
    seq[0] = '{pc: 16'h0020, instr: 16'h1234, branch: 1'b1, hlt: 1'b0};
    seq[1] = '{pc: 16'h0022, instr: 16'h5678, branch: 1'b0, hlt: 1'b0};
    seq[2] = '{pc: 16'h0024, instr: 16'hF000, branch: 1'b0, hlt: 1'b1};
    ia.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_a(seq[i]); sb.push_back(seq[i]); tick();
    end
    ia.in_valid = 1'b0;
    total++; if (ia.halted !== 1'b1 || ia.in_ready !== 1'b0 || ia.count !== 3'd3) begin bad++; $display("FAIL halt_set got=%b/%b/%0d exp=1/0/3", ia.halted, ia.in_ready, ia.count); end
    e = '{pc: 16'h0026, instr: 16'h1111, branch: 1'b0, hlt: 1'b0};
    drive_a(e); tick(); ia.in_valid = 1'b0;
    total++; if (ia.count !== 3'd3) begin bad++; $display("FAIL halt_block got=%0d exp=3", ia.count); end
    ia.out_ready = 1'b1;
    for (int g = 0; g < 6 && sb.size() > 0; g++) begin
      exp = sb.pop_front();
      total++; if (ia.in_ready !== 1'b0 || {ia.pc_out, ia.instr_out, ia.branch_out, ia.hlt_out} !== exp) begin
        bad++; $display("FAIL halt_drain got=%h/%h/%b/%b rdy=%b exp=%h/%h/%b/%b rdy=0", ia.pc_out, ia.instr_out, ia.branch_out, ia.hlt_out, ia.in_ready, exp.pc, exp.instr, exp.branch, exp.hlt);
      end
      tick();
    end
    total++; if (ia.halted !== 1'b1 || ia.in_ready !== 1'b0 || ia.count !== 3'd0 || ia.hlt_out !== 1'b0) begin bad++; $display("FAIL halt_after got=%b/%b/%0d/%b exp=1/0/0/0", ia.halted, ia.in_ready, ia.count, ia.hlt_out); end
    ia.flush = 1'b1; tick(); ia.flush = 1'b0; ia.out_ready = 1'b0;
    total++; if (ia.halted !== 1'b0 || ia.in_ready !== 1'b1) begin bad++; $display("FAIL halt_clear got=%b/%b exp=0/1", ia.halted, ia.in_ready); end
  endtask

  task automatic test_flush();
    if_id_entry_t e;
    sb.delete();
    ia.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = '{pc: 16'h0030 + 16'(2 * i), instr: 16'h3000 + 16'(i), branch: 1'b0, hlt: 1'b0};
      drive_a(e); tick();
    end
    ia.in_valid = 1'b0;
    total++; if (ia.count !== 3'd3) begin bad++; $display("FAIL flush_pre got=%0d exp=3", ia.count); end
    e = '{pc: 16'h0077, instr: 16'h2222, branch: 1'b1, hlt: 1'b0};
    drive_a(e); ia.flush = 1'b1; ia.out_ready = 1'b1; tick();
    ia.flush = 1'b0; ia.in_valid = 1'b0;
    total++; if (ia.count !== 3'd0 || ia.out_valid !== 1'b0 || ia.instr_out !== 16'h7000 || ia.pc_out !== 16'h0) begin
      bad++; $display("FAIL flush_empty got=%0d/%b/%h/%h exp=0/0/7000/0000", ia.count, ia.out_valid, ia.instr_out, ia.pc_out);
    end
    tick();
    total++; if (ia.out_valid !== 1'b0 || ia.count !== 3'd0) begin bad++; $display("FAIL flush_lost got=%b/%0d exp=0/0", ia.out_valid, ia.count); end
    ia.out_ready = 1'b0;
    e = '{pc: 16'h0040, instr: 16'h3333, branch: 1'b0, hlt: 1'b0};
    drive_a(e); tick(); ia.in_valid = 1'b0;
    total++; if (ia.count !== 3'd1 || ia.pc_out !== 16'h0040 || ia.instr_out !== 16'h3333) begin
      bad++; $display("FAIL flush_reuse got=%0d/%h/%h exp=1/0040/3333", ia.count, ia.pc_out, ia.instr_out);
    end
    ia.out_ready = 1'b1; tick(); ia.out_ready = 1'b0;
    total++; if (ia.count !== 3'd0) begin bad++; $display("FAIL flush_pop got=%0d exp=0", ia.count); end
  endtask

  task automatic test_rst_mid();
    if_id_entry_t e;
    ia.out_ready = 1'b0;
    e = '{pc: 16'h0050, instr: 16'h4444, branch: 1'b1, hlt: 1'b0};
    drive_a(e); tick();
    e = '{pc: 16'h0052, instr: 16'hF00F, branch: 1'b0, hlt: 1'b1};
    drive_a(e); tick(); ia.in_valid = 1'b0;
    total++; if (ia.halted !== 1'b1 || ia.count !== 3'd2 || ia.pc_out !== 16'h0050) begin bad++; $display("FAIL rst_pre got=%b/%0d/%h exp=1/2/0050", ia.halted, ia.count, ia.pc_out); end
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (ia.out_valid !== 1'b0 || ia.instr_out !== 16'h7000 || ia.pc_out !== 16'h0 || ia.branch_out !== 1'b0 || ia.hlt_out !== 1'b0) begin
      bad++; $display("FAIL rst_head got=%b/%h/%h/%b/%b exp=0/7000/0000/0/0", ia.out_valid, ia.instr_out, ia.pc_out, ia.branch_out, ia.hlt_out);
    end
    total++; if (ia.halted !== 1'b0 || ia.in_ready !== 1'b1 || ia.count !== 3'd0) begin bad++; $display("FAIL rst_state got=%b/%b/%0d exp=0/1/0", ia.halted, ia.in_ready, ia.count); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_halt();
    test_flush();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
